// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter in front of a single shared memory port
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              we0,
    input  logic              we1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_out,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_data_in
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state_q, state_d;
    logic id_q, last_q, we_q, rvalid0_q, rvalid1_q, pick, take;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata0_q, rdata1_q;
    assign take = state_q == IDLE && (req0 || req1);
    assign pick = (req0 && req1) ? ~last_q : req1;
    // state register; reset aborts any transaction in flight
    always_ff @(posedge clk) begin
        state_q <= resetn ? state_d : IDLE;
    end
    // fixed IDLE -> ACCESS -> RESP -> IDLE walk, leaving IDLE only on a request
    always_comb begin
        state_d = state_q == IDLE   ? ((req0 || req1) ? ACCESS : IDLE) :
                  state_q == ACCESS ? RESP : IDLE;
    end
    // memory strobes and grant pulses exist only during the single ACCESS cycle
    always_comb begin
        gnt0         = state_q == ACCESS && !id_q;
        gnt1         = state_q == ACCESS && id_q;
        mem_we       = state_q == ACCESS && we_q;
        mem_data_out = (state_q == ACCESS && we_q) ? wdata_q : '0;
    end
    // latch the winner in IDLE, complete it at the RESP edge
    always_ff @(posedge clk) begin
        if (!resetn) begin
            id_q      <= 1'b0;
            last_q    <= 1'b1;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            if (take) begin
                id_q    <= pick;
                addr_q  <= pick ? addr1 : addr0;
                wdata_q <= pick ? wdata1 : wdata0;
                we_q    <= pick ? we1 : we0;
            end
            rvalid0_q <= state_q == RESP && !id_q;
            rvalid1_q <= state_q == RESP && id_q;
            if (state_q == RESP) last_q <= id_q;
            if (state_q == RESP && !we_q && !id_q) rdata0_q <= mem_data_in;
            if (state_q == RESP && !we_q && id_q) rdata1_q <= mem_data_in;
        end
    end
    assign mem_address = addr_q;
    assign rvalid0     = rvalid0_q;
    assign rvalid1     = rvalid1_q;
    assign rdata0      = rdata0_q;
    assign rdata1      = rdata1_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed-vector self-checking bench for mem_arbiter
module tb_mem_arbiter;
    logic        clk = 1'b0, resetn = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0, mem_data_in = '0;
    logic        gnt0, gnt1, rvalid0, rvalid1, mem_we;
    logic [31:0] rdata0, rdata1, mem_address, mem_data_out;
    int          n_cmp = 0, n_err = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1), .we0(we0), .we1(we1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_address(mem_address), .mem_data_out(mem_data_out), .mem_we(mem_we),
        .mem_data_in(mem_data_in)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // tie sequence: {gnt0, gnt1, rvalid0, rvalid1} per cycle with both requesters held high
    logic [3:0] tie_exp [9] = '{4'b1000, 4'b0000, 4'b0010, 4'b0100, 4'b0000,
                                4'b0001, 4'b1000, 4'b0000, 4'b0010};

    initial begin
        step();
        step();
        check("rst_gnt",  32'({gnt0, gnt1}), 32'h0);
        check("rst_rv",   32'({rvalid0, rvalid1}), 32'h0);
        check("rst_we",   32'(mem_we), 32'h0);
        check("rst_addr", mem_address, 32'h0);
        check("rst_dout", mem_data_out, 32'h0);
        check("rst_rd",   rdata0 | rdata1, 32'h0);
        resetn = 1'b1;
        // single read from requester 0
        req0 = 1'b1; addr0 = 32'h10; we0 = 1'b0; wdata0 = 32'h1234; mem_data_in = 32'hCAFEBABE;
        step();
        check("rd_gnt",  32'({gnt0, gnt1}), 32'h2);
        check("rd_addr", mem_address, 32'h10);
        check("rd_we",   32'(mem_we), 32'h0);
        check("rd_dout", mem_data_out, 32'h0);
        req0 = 1'b0;
        step();
        check("rd_resp_gnt",  32'({gnt0, gnt1}), 32'h0);
        check("rd_resp_rv",   32'({rvalid0, rvalid1}), 32'h0);
        check("rd_resp_addr", mem_address, 32'h10);
        step();
        check("rd_rv",    32'({rvalid0, rvalid1}), 32'h2);
        check("rd_rdata", rdata0, 32'hCAFEBABE);
        step();
        check("rd_rv_pulse", 32'({rvalid0, rvalid1}), 32'h0);
        // single write from requester 1
        req1 = 1'b1; addr1 = 32'h20; wdata1 = 32'h55; we1 = 1'b1; mem_data_in = 32'hDEADBEEF;
        step();
        check("wr_gnt",  32'({gnt0, gnt1}), 32'h1);
        check("wr_we",   32'(mem_we), 32'h1);
        check("wr_addr", mem_address, 32'h20);
        check("wr_dout", mem_data_out, 32'h55);
        req1 = 1'b0;
        step();
        check("wr_we_off",   32'(mem_we), 32'h0);
        check("wr_addr_hld", mem_address, 32'h20);
        step();
        check("wr_rv",     32'({rvalid0, rvalid1}), 32'h1);
        check("wr_rdata1", rdata1, 32'h0);
        check("wr_rdata0", rdata0, 32'hCAFEBABE);
        check("wr_we_idle", 32'(mem_we), 32'h0);
        // tie after reset alternates starting with requester 0
        resetn = 1'b0;
        step();
        resetn = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 32'h40; addr1 = 32'h44;
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            check($sformatf("tie_c%0d", i), 32'({gnt0, gnt1, rvalid0, rvalid1}), 32'(tie_exp[i]));
            check($sformatf("tie_we%0d", i), 32'(mem_we), 32'h0);
        end
        req0 = 1'b0; req1 = 1'b0;
        // one-cycle req1 glitch during requester 0's ACCESS is ignored
        step();
        req0 = 1'b1; we0 = 1'b0;
        step();
        check("gl_gnt", 32'({gnt0, gnt1}), 32'h2);
        req0 = 1'b0; req1 = 1'b1;
        step();
        req1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("gl_c%0d", i), 32'({gnt1, rvalid1}), 32'h0);
            step();
        end
        // reset during a write's ACCESS cycle aborts it
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h30; wdata1 = 32'hAA;
        step();
        check("ab_we_acc", 32'(mem_we), 32'h1);
        req1 = 1'b0; resetn = 1'b0;
        step();
        check("ab_we",   32'(mem_we), 32'h0);
        check("ab_gnt",  32'({gnt0, gnt1}), 32'h0);
        check("ab_addr", mem_address, 32'h0);
        resetn = 1'b1;
        step();
        check("ab_norv", 32'({rvalid0, rvalid1}), 32'h0);
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        step();
        check("ab_tie", 32'({gnt0, gnt1}), 32'h2);
        req0 = 1'b0; req1 = 1'b0;
        step();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 The block SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-004 The block SHALL have port resetn  input  1  synchronous, active-low reset.
REQ-005 The block SHALL have ports req0/req1  input  1  access request from requester 0/1.
REQ-006 The block SHALL have ports addr0/addr1  input  ADDR_W  request address.
REQ-007 The block SHALL have ports wdata0/wdata1  input  DATA_W  write data.
REQ-008 The block SHALL have ports we0/we1  input  1  1 = write, 0 = read.
REQ-009 The block SHALL have ports gnt0/gnt1  output  1  one-cycle pulse: request accepted.
REQ-010 The block SHALL have ports rvalid0/rvalid1  output  1  one-cycle pulse: transaction complete.
REQ-011 The block SHALL have ports rdata0/rdata1  output  DATA_W  read data, valid while rvalid is high after a read.
REQ-012 The block SHALL have port mem_address  output  ADDR_W  shared memory address.
REQ-013 The block SHALL have port mem_data_out  output  DATA_W  shared memory write data.
REQ-014 The block SHALL have port mem_we  output  1  shared memory write enable.
REQ-015 The block SHALL have port mem_data_in  input  DATA_W  memory read data, valid one cycle after address is presented.

Function
REQ-016 The FSM SHALL have states IDLE, ACCESS and RESP.
REQ-017 In IDLE, at each edge with req0 or req1 high, the block SHALL latch the winner's id, addr, wdata and we and go to ACCESS; with no request it SHALL stay in IDLE.
REQ-018 Winner selection: a single requester wins; if both request, the one not granted last wins (round-robin pointer).
REQ-019 During ACCESS (one cycle), the block SHALL drive mem_address = latched addr, mem_we = latched we, mem_data_out = latched wdata for writes (0 for reads), and pulse gnt of the winner only.
REQ-020 From ACCESS, the block SHALL unconditionally go to RESP and clear mem_we; mem_address SHALL hold its value through RESP.
REQ-021 At the RESP edge, the block SHALL set rvalid of the winner for one cycle, load the winner's rdata with mem_data_in for reads (rdata unchanged for writes), update the round-robin pointer to the winner, and return to IDLE.
REQ-022 Latency SHALL be: req sampled at edge N -> gnt high cycle N+1 -> rvalid high cycle N+3; the maximum throughput is one transaction per 3 cycles.
REQ-023 A request deasserted before an IDLE sampling edge SHALL be ignored; a req still high at an IDLE edge (including the rvalid cycle) SHALL count as a new request.
REQ-024 Requester inputs SHALL be ignored outside IDLE; changes during ACCESS or RESP SHALL NOT affect the transaction in flight.
REQ-025 gnt0 and gnt1 SHALL never be high together; rvalid0 and rvalid1 SHALL never be high together; mem_we SHALL be high only in ACCESS.
REQ-026 With both requesters held high continuously, grants SHALL strictly alternate and neither requester SHALL wait more than one transaction.

Reset
REQ-027 While resetn = 0 at an edge, the block SHALL enter IDLE and drive all outputs to 0, with the round-robin pointer set so that requester 0 wins the first tie.
REQ-028 A reset during ACCESS or RESP SHALL abort the transaction: mem_we goes to 0 at that edge and no rvalid is issued.

Verification
REQ-029 Single read: req0 = 1, addr0 = 0x10, we0 = 0, memory returns 0xCAFEBABE -> gnt0 in cycle +1, mem_address = 0x10, rvalid0 in cycle +3 with rdata0 = 0xCAFEBABE.
REQ-030 Single write: req1 = 1, addr1 = 0x20, wdata1 = 0x55, we1 = 1 -> mem_we = 1 for exactly one cycle with mem_address = 0x20 and mem_data_out = 0x55, then rvalid1 pulse with rdata1 unchanged.
REQ-031 Tie after reset: req0 and req1 rise together -> gnt0 first, then gnt1, then gnt0; no cycle has both gnts high.
REQ-032 Request glitch: req1 high for one cycle while the FSM is in ACCESS serving requester 0 -> no gnt1 or rvalid1 ever issued.
REQ-033 Reset mid-operation: resetn = 0 during the ACCESS cycle of a write -> mem_we = 0 the next cycle, no rvalid, FSM in IDLE, next tie granted to requester 0.
